ysyx_22040038_ifu: RTL and testbench
====================================

YSYX_22040038_IFU -- requirements
Module: ysyx_22040038_ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_req_addr  output  64  fetch address; bits [1:0] always 0.
REQ-007 imem_rsp_valid  input  1  response data valid, single-cycle pulse.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instruction available to the decode stage.
REQ-010 instr_ready  input  1  decode stage consumes instruction.
REQ-011 instr_o  output  32  held instruction word, feeds the decoder's instr_i.
REQ-012 pc_o  output  64  address the held instruction was fetched from.
REQ-013 redirect_valid  input  1  branch/jump redirect pulse from execute.
REQ-014 redirect_pc  input  64  redirect target; bits [1:0] SHALL be ignored (forced 0).
REQ-015 fetch_cnt  output  64  count of instructions handed to decode.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD; one-hot or binary encoding at implementer's choice.
REQ-017 IDLE: all handshake outputs 0; next state REQ unconditionally.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT; else stay REQ.
REQ-019 WAIT: on imem_rsp_valid with drop=0 -> HOLD, latch imem_rsp_data into instr_o and pc into pc_o.
REQ-020 WAIT: on imem_rsp_valid with drop=1 -> discard data, clear drop, go REQ.
REQ-021 HOLD: instr_valid=1, instr_o/pc_o stable; on instr_ready -> pc<=pc+4, fetch_cnt+1, go REQ.
REQ-022 Latency: request accepted cycle N, response cycle M>N -> instr_valid high from cycle M+1.
REQ-023 No more than one request SHALL be outstanding; imem_req_valid=0 in WAIT and HOLD.
REQ-024 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0); fetch_cnt SHALL wrap likewise.
REQ-025 Redirect has priority over every other event in the same cycle; pc<={redirect_pc[63:2],2'b00}.
REQ-026 Redirect in REQ with imem_req_ready=0: stay REQ, new address presented next cycle.
REQ-027 Redirect in REQ with imem_req_ready=1: go WAIT with drop=1 (accepted request is stale).
REQ-028 Redirect in WAIT (including same cycle as imem_rsp_valid): if rsp_valid same cycle, discard and go REQ; else set drop=1, stay WAIT.
REQ-029 Redirect in HOLD: instr_valid drops next cycle, no fetch_cnt increment even if instr_ready=1, go REQ.
REQ-030 Redirect in IDLE: pc updated, go REQ.
REQ-031 imem_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-032 rst=1 at posedge: state=IDLE, pc=RESET_PC, drop=0, fetch_cnt=0, instr_o=0, pc_o=0, all valid outputs 0, from the next cycle.
REQ-033 rst SHALL override redirect and all handshakes; reset mid-WAIT abandons the outstanding request and any later response is ignored per REQ-031.

Verification
REQ-034 Reset release, imem_req_ready=1, rsp 1 cycle later data 32'h00000413 -> first request addr 64'h8000_0000, instr_valid with instr_o=32'h00000413, pc_o=64'h8000_0000.
REQ-035 instr_ready held 1, memory always ready, 3 fetches -> addrs 0x8000_0000, 0x8000_0004, 0x8000_0008; fetch_cnt=3.
REQ-036 instr_ready=0 for 5 cycles in HOLD -> instr_o/pc_o unchanged, no new request, fetch_cnt unchanged.
REQ-037 Redirect to 64'h8000_0103 during WAIT, then rsp 32'hDEADBEEF -> data discarded, next request addr 64'h8000_0100, no instr_valid for stale word.
REQ-038 Redirect and instr_ready same cycle in HOLD -> fetch_cnt not incremented, next addr = redirect target.
REQ-039 rst pulse in WAIT, late rsp arrives during IDLE/REQ -> ignored; next addr 64'h8000_0000.

Source files
------------

// File: rtl/ysyx_22040038_ifu.sv
// Instruction fetch unit: one outstanding memory request at a time. It holds the fetched
// word for decode and handles redirects, which can make an in-flight response stale.
module ysyx_22040038_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  localparam logic [63:0] ResetPcAligned = RESET_PC & ~64'h3;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_hold_q, pc_hold_d;
  logic [63:0] redir_pc;

  assign redir_pc = redirect_pc & ~64'h3;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    pc_hold_d = pc_hold_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect_valid) pc_d = redir_pc;
      end
      StReq: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          // The request accepted this cycle carried the old pc, so its response is stale.
          if (imem_req_ready) begin
            state_d = StWait;
            drop_d  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (imem_rsp_valid) begin
            state_d = StReq;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            state_d   = StHold;
            instr_d   = imem_rsp_data;
            pc_hold_d = pc_q;
          end
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = StReq;
        end else if (instr_ready) begin
          pc_d    = pc_q + 64'd4;
          cnt_d   = cnt_q + 64'd1;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= ResetPcAligned;
      drop_q    <= 1'b0;
      cnt_q     <= 64'd0;
      instr_q   <= 32'd0;
      pc_hold_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      pc_hold_q <= pc_hold_d;
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == StHold);
  assign instr_o        = instr_q;
  assign pc_o           = pc_hold_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ysyx_22040038_ifu.sv
// Scoreboard bench for the fetch unit: the driver models memory and the expected fetch
// stream; a separate monitor checks each held instruction against the expectation queue.
module tb_ysyx_22040038_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic [63:0] fetch_cnt;

  ysyx_22040038_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_pc = RESET_PC;
  logic [63:0] m_cnt = 64'd0;
  logic [63:0] outst_addr = 64'd0;
  bit          outst = 1'b0;
  bit          outst_stale = 1'b0;
  logic [31:0] cyc = 32'd0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == RESET_PC) return 32'h0000_0413;
    return (a[33:2] * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired (got timeout, expected completion)", name);
  endtask

  // One clock cycle of stimulus: memory model plus expected-fetch-stream bookkeeping.
  task automatic step(input bit rst_v, input bit rr, input bit ir, input bit rd,
                      input logic [63:0] rt, input bit rsp_en, input bit junk);
    bit   fire;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      chk("one_outstanding", 64'(imem_req_valid && outst), 64'd0);
      chk("req_while_hold", 64'(imem_req_valid && (exp_q.size() != 0)), 64'd0);
    end
    rst            = rst_v;
    imem_req_ready = rr;
    instr_ready    = ir;
    redirect_valid = rd;
    redirect_pc    = rt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    if (rst_v) begin
      m_pc        = RESET_PC;
      m_cnt       = 64'd0;
      outst       = 1'b0;
      outst_stale = 1'b0;
      exp_q.delete();
    end else begin
      fire = rsp_en && outst;
      if (junk && !outst) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      if (fire) begin
        imem_rsp_valid = 1'b1;
        if (outst_stale || rd) begin
          imem_rsp_data = 32'hDEAD_BEEF;
        end else begin
          imem_rsp_data = mem_word(outst_addr);
          e.pc   = outst_addr;
          e.data = imem_rsp_data;
          e.cyc  = cyc;
          exp_q.push_back(e);
        end
        outst = 1'b0;
      end
      if (imem_req_valid && rr) begin
        chk("req_addr", imem_req_addr, m_pc);
        outst       = 1'b1;
        outst_addr  = m_pc;
        outst_stale = rd;
      end
      if (rd) begin
        m_pc = rt & ~64'h3;
        if (outst) outst_stale = 1'b1;
        exp_q.delete();
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents to decode against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      chk("fetch_cnt", fetch_cnt, m_cnt);
      if (!redirect_valid) begin
        if (exp_q.size() == 0 || exp_q[0].cyc == cyc) begin
          chk("instr_valid_idle", 64'(instr_valid), 64'd0);
        end else begin
          chk("instr_valid_hold", 64'(instr_valid), 64'd1);
          chk("instr_o", 64'(instr_o), 64'(exp_q[0].data));
          chk("pc_o", pc_o, exp_q[0].pc);
          if (instr_valid && instr_ready) begin
            e     = exp_q.pop_front();
            m_cnt = m_cnt + 64'd1;
            m_pc  = e.pc + 64'd4;
          end
        end
      end
    end
  end

  task automatic run_until_outst(input string name);
    int n = 0;
    while (!outst && n < 40) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
      n++;
    end
    if (!outst) timeout(name);
  endtask

  task automatic run_until_cnt(input string name, input logic [63:0] target);
    int n = 0;
    while (m_cnt != target && n < 80) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
      n++;
    end
    if (m_cnt != target) timeout(name);
  endtask

  initial begin
    logic [63:0] c0;
    int          n;
    logic [63:0] rt;

    // Reset state
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr_o", 64'(instr_o), 64'd0);
    chk("rst_pc_o", pc_o, 64'd0);
    chk("rst_fetch_cnt", fetch_cnt, 64'd0);

    // First fetch, then hold for several cycles with decode stalled
    n = 0;
    while (exp_q.size() == 0 && n < 20) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
      n++;
    end
    if (exp_q.size() == 0) timeout("first_fetch");
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    chk("first_instr_o", 64'(instr_o), 64'h0000_0413);
    chk("first_pc_o", pc_o, RESET_PC);

    // Streaming fetches
    run_until_cnt("three_fetches", 64'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    #2;
    chk("fetch_cnt_3", fetch_cnt, 64'd3);

    // Redirect during WAIT makes the response stale
    run_until_outst("wait_redirect_accept");
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0103, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    run_until_outst("after_stale");
    chk("redirect_target", outst_addr, 64'h0000_0000_8000_0100);

    // Redirect and instr_ready together in HOLD
    n = 0;
    while (exp_q.size() == 0 && n < 40) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
      n++;
    end
    if (exp_q.size() == 0) timeout("reach_hold");
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    c0 = m_cnt;
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_2000, 1'b0, 1'b0);
    run_until_outst("hold_redirect");
    chk("hold_redirect_target", outst_addr, 64'h0000_0000_8000_2000);
    chk("hold_redirect_cnt", fetch_cnt, c0);

    // pc wraps at the top of the address space
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    run_until_cnt("wrap_fetch", m_cnt + 64'd1);
    run_until_outst("wrap_next");
    chk("wrap_addr", outst_addr, 64'd0);

    // Reset during WAIT; a late response arrives in IDLE and REQ
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    run_until_outst("post_reset_req");
    chk("post_reset_addr", outst_addr, RESET_PC);
    run_until_cnt("post_reset_fetch", 64'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else rt = {$urandom, $urandom};
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0, rt, $urandom_range(0, 1) == 1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
